// File: rtl/fader_pkg.sv
// rtl/fader_pkg.sv - shared state and command encodings for the fade sequencer
package fader_pkg;

  typedef logic [1:0] fade_state_t;

  localparam fade_state_t ST_MUTED     = 2'd0;
  localparam fade_state_t ST_RAMP_UP   = 2'd1;
  localparam fade_state_t ST_RAMP_DOWN = 2'd2;
  localparam fade_state_t ST_FULL      = 2'd3;

  typedef enum logic [1:0] {
    OP_FADE_IN  = 2'b00,
    OP_FADE_OUT = 2'b01,
    OP_SET_FULL = 2'b10,
    OP_SET_MUTE = 2'b11
  } fade_op_e;

endpackage

// File: rtl/fade_rate_div.sv
// rtl/fade_rate_div.sv - strobe divider producing one gain-step tick every (rate+1) strobes
module fade_rate_div
  import fader_pkg::*;
#(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clear,
  input  logic              load,
  input  logic [RATE_W-1:0] rate,
  input  logic              enable,
  input  logic              strobe,
  output logic              tick
);

  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] rate_q;

  // Tick is combinational so the gain steps on the same edge as the counter wraps.
  assign tick = enable && strobe && (cnt == rate_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt    <= '0;
      rate_q <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt    <= '0;
      rate_q <= rate;
    end else if (enable && strobe) begin
      cnt <= tick ? '0 : cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/fade_sequencer.sv
// rtl/fade_sequencer.sv - command-driven gain ramp sequencer for the fader datapath
module fade_sequencer
  import fader_pkg::*;
#(
  parameter int GAIN_W = 4,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clear,
  input  logic              sample_strobe,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic [GAIN_W-1:0] gain,
  output logic              fad_enable,
  output logic              busy,
  output logic              done
);

  localparam logic [GAIN_W-1:0] GAIN_FULL = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);

  fade_state_t       state;
  logic [GAIN_W-1:0] gain_q;
  logic              done_q;
  logic              accept;
  logic              step;
  fade_op_e          op;

  assign op         = fade_op_e'(cmd_op);
  assign busy       = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
  assign cmd_ready  = ((state == ST_MUTED) || (state == ST_FULL)) && !clear;
  assign accept     = cmd_valid && cmd_ready;
  assign gain       = gain_q;
  assign fad_enable = |gain_q;
  assign done       = done_q;

  fade_rate_div #(.RATE_W(RATE_W)) u_rate_div (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (clear),
    .load    (accept),
    .rate    (cmd_rate),
    .enable  (busy),
    .strobe  (sample_strobe),
    .tick    (step)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= ST_MUTED;
      gain_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state  <= ST_MUTED;
        gain_q <= '0;
      end else if (accept) begin
        case (op)
          // A fade already at its target completes at once without moving gain.
          OP_FADE_IN: begin
            if (gain_q == GAIN_FULL) done_q <= 1'b1;
            else                     state  <= ST_RAMP_UP;
          end
          OP_FADE_OUT: begin
            if (gain_q == '0) done_q <= 1'b1;
            else              state  <= ST_RAMP_DOWN;
          end
          OP_SET_FULL: begin
            gain_q <= GAIN_FULL;
            state  <= ST_FULL;
            done_q <= 1'b1;
          end
          OP_SET_MUTE: begin
            gain_q <= '0;
            state  <= ST_MUTED;
            done_q <= 1'b1;
          end
        endcase
      end else if (step) begin
        if (state == ST_RAMP_UP) begin
          gain_q <= gain_q + GAIN_ONE;
          if (gain_q == GAIN_FULL - GAIN_ONE) begin
            state  <= ST_FULL;
            done_q <= 1'b1;
          end
        end else begin
          gain_q <= gain_q - GAIN_ONE;
          if (gain_q == GAIN_ONE) begin
            state  <= ST_MUTED;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/fade_sequencer.md
FADE_SEQUENCER -- requirements
Module: fade_sequencer

Interface
REQ-001 SHALL have parameter GAIN_W, default 4, gain width; full scale is 2^GAIN_W-1.
REQ-002 SHALL have parameter RATE_W, default 8, step-interval field width.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous abort to muted state.
REQ-006 SHALL have port sample_strobe, input, 1, one-cycle pulse per audio sample.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command can be accepted.
REQ-009 SHALL have port cmd_op, input, 2, 00 FADE_IN, 01 FADE_OUT, 10 SET_FULL, 11 SET_MUTE.
REQ-010 SHALL have port cmd_rate, input, RATE_W, strobes per gain step minus one.
REQ-011 SHALL have port gain, output, GAIN_W, multiplier value driven to the fader datapath.
REQ-012 SHALL have port fad_enable, output, 1, high whenever gain is nonzero.
REQ-013 SHALL have port busy, output, 1, high while ramping.
REQ-014 SHALL have port done, output, 1, one-cycle pulse on command completion.

Function
REQ-015 SHALL implement states MUTED, RAMP_UP, RAMP_DOWN, FULL.
REQ-016 SHALL drive cmd_ready=1 only in MUTED or FULL with clear low.
REQ-017 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high; cmd_rate latched then.
REQ-018 FADE_IN accepted SHALL enter RAMP_UP; FADE_OUT SHALL enter RAMP_DOWN; step counter reset to 0.
REQ-019 SET_FULL SHALL set gain to full scale, enter FULL and pulse done on the edge after acceptance.
REQ-020 SET_MUTE SHALL set gain to 0, enter MUTED and pulse done on the edge after acceptance.
REQ-021 In a ramp state, each sample_strobe SHALL increment the step counter; when the counter equals latched rate, gain SHALL step by 1 and counter SHALL return to 0.
REQ-022 RAMP_UP reaching full scale SHALL enter FULL and pulse done on the same edge as the final step.
REQ-023 RAMP_DOWN reaching 0 SHALL enter MUTED and pulse done on the same edge as the final step.
REQ-024 FADE_IN with gain already full scale (or FADE_OUT with gain 0) SHALL complete with done on the next edge, gain unchanged.
REQ-025 cmd_rate=0 SHALL step gain on every strobe; gain SHALL never wrap past 0 or full scale.
REQ-026 Strobes outside ramp states SHALL be ignored.
REQ-027 busy SHALL equal (state is RAMP_UP or RAMP_DOWN).
REQ-028 clear SHALL, on the next edge, force MUTED, gain 0, counter 0, done 0, overriding any simultaneous command or strobe.

Reset
REQ-029 n_reset low SHALL immediately force MUTED, gain 0, counter 0, latched rate 0, done 0, busy 0, fad_enable 0; cmd_ready SHALL read 1 after release.
REQ-030 Reset mid-ramp SHALL abandon the ramp without done.

Structure
REQ-031 State enum and cmd_op encodings SHALL live in shared package fader_pkg.
REQ-032 Step interval counter SHALL be sub-module fade_rate_div (load, strobe in, tick out).

Verification
REQ-033 Reset, FADE_IN rate=2, strobe every 4 cycles -> gain steps every 3rd strobe, 0..15 after 45 strobes, done once, state FULL.
REQ-034 From FULL, FADE_OUT rate=0 -> gain falls 15..0 over 15 strobes, done on the 15th, fad_enable low afterwards.
REQ-035 cmd_valid during RAMP_UP -> cmd_ready 0, command not accepted, ramp unaffected.
REQ-036 clear asserted with cmd_valid and strobe at gain=7 in RAMP_UP -> next cycle gain 0, MUTED, no done, command dropped.
REQ-037 SET_FULL from MUTED -> gain 15 and done one edge after acceptance; then FADE_IN -> done next edge, gain stays 15.
REQ-038 n_reset pulled low asynchronously mid-RAMP_DOWN at gain=9 -> gain 0 immediately, no done.
